// File: rtl/gnrl_arb_master_pkg.sv
// ============================================================================
// Module  : gnrl_arb_master_pkg
// Brief   : Shared one-hot state encodings for the arbiter requester agent.
// Revision: 1.0
// ============================================================================
`default_nettype none

package gnrl_arb_master_pkg;

  localparam int unsigned STATE_W = 4;

  // One-hot IDs; the arbiter side decodes the same constants.
  localparam logic [STATE_W-1:0] S_IDLE    = 4'b0001;
  localparam logic [STATE_W-1:0] S_REQ     = 4'b0010;
  localparam logic [STATE_W-1:0] S_XFER    = 4'b0100;
  localparam logic [STATE_W-1:0] S_RELEASE = 4'b1000;

endpackage

`default_nettype wire

// File: rtl/gnrl_arb_cmd_fifo.sv
// ============================================================================
// Module  : gnrl_arb_cmd_fifo
// Brief   : Synchronous command FIFO with wrap-bit pointers, no pop bypass.
// Revision: 1.0
// ============================================================================
`default_nettype none

module gnrl_arb_cmd_fifo #(
  parameter int unsigned W     = 36,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_wdata,
  output logic [W-1:0] o_rdata,
  output logic         o_full,
  output logic         o_empty
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [PW:0]  wptr_q;
  logic [PW:0]  rptr_q;
  logic         w_do_push;
  logic         w_do_pop;

  // Equal index with differing wrap bits means every entry is occupied.
  assign o_empty   = (wptr_q == rptr_q);
  assign o_full    = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_rdata   = mem_q[rptr_q[PW-1:0]];

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      mem_q[wptr_q[PW-1:0]] <= i_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (w_do_push) wptr_q <= wptr_q + (PW+1)'(1);
      if (w_do_pop)  rptr_q <= rptr_q + (PW+1)'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/gnrl_arb_master.sv
// ============================================================================
// Module  : gnrl_arb_master
// Brief   : Requester agent: queues commands, arbitrates, drives bursts, releases.
// Revision: 1.0
// ============================================================================
`default_nettype none

module gnrl_arb_master
  import gnrl_arb_master_pkg::*;
#(
  parameter int unsigned AW       = 32,
  parameter int unsigned LW       = 4,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned ADDR_INC = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_cmd_valid,
  output logic          o_cmd_ready,
  input  logic [AW-1:0] i_cmd_addr,
  input  logic [LW-1:0] i_cmd_len,
  output logic          o_req,
  input  logic          i_gnt,
  output logic          o_end_access,
  output logic          o_bus_valid,
  output logic [AW-1:0] o_bus_addr,
  output logic          o_bus_last,
  input  logic          i_bus_ready,
  output logic          o_err
);

  logic [STATE_W-1:0] state_q, state_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [LW-1:0]      cnt_q, cnt_d;
  logic               req_q;
  logic               end_q;
  logic               err_q;

  logic [AW+LW-1:0]   w_head;
  logic               w_full;
  logic               w_empty;
  logic               w_xfer;
  logic               w_beat;
  logic               w_last_beat;

  gnrl_arb_cmd_fifo #(
    .W     (AW + LW),
    .DEPTH (DEPTH)
  ) u_cmd_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (i_cmd_valid),
    .i_pop   (w_last_beat),
    .i_wdata ({i_cmd_addr, i_cmd_len}),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_xfer      = (state_q == S_XFER);
  assign w_beat      = o_bus_valid && i_bus_ready;
  assign w_last_beat = w_beat && (cnt_q == '0);

  assign o_cmd_ready  = !w_full;
  assign o_req        = req_q;
  assign o_end_access = end_q;
  assign o_bus_valid  = w_xfer && i_gnt;
  assign o_bus_addr   = addr_q;
  assign o_bus_last   = w_xfer && (cnt_q == '0);
  assign o_err        = err_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (!w_empty) state_d = S_REQ;
      S_REQ:     if (i_gnt) state_d = S_XFER;
      S_XFER:    if (w_last_beat) state_d = S_RELEASE;
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    addr_d = addr_q;
    cnt_d  = cnt_q;
    if ((state_q == S_REQ) && i_gnt) begin
      addr_d = w_head[AW+LW-1:LW];
      cnt_d  = w_head[LW-1:0];
    end else if (w_beat) begin
      addr_d = addr_q + AW'(ADDR_INC);
      cnt_d  = cnt_q - LW'(1);
    end
  end

  // req/end_access are registered off the next state so they align with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      end_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      req_q   <= (state_d == S_REQ) || (state_d == S_XFER);
      end_q   <= (state_d == S_RELEASE);
      if (w_xfer && !i_gnt) err_q <= 1'b1;
    end
  end

endmodule

`default_nettype wire
